// File: rtl/gate_bist_if.sv
// Bus between the BIST sequencer and its environment: run handshake,
// gate-under-test stimulus/response and the reported results.
interface gate_bist_if;
  logic       start;
  logic       dut_out;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] result_vec;
  logic [3:0] fail_mask;

  modport master (
    output start, dut_out,
    input  dut_a, dut_b, busy, done, pass, result_vec, fail_mask
  );

  modport slave (
    input  start, dut_out,
    output dut_a, dut_b, busy, done, pass, result_vec, fail_mask
  );
endinterface

// File: rtl/gate_bist.sv
// Built-in self-test sequencer for a two-input logic gate: walks the four
// input vectors, samples the response after a settle time, checks a truth table.
module gate_bist #(
  parameter logic [3:0] EXPECTED      = 4'b1000,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  gate_bist_if.slave io_bus
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic        r_a;
  logic        r_b;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [3:0]  r_result;
  logic [3:0]  r_fail;
  logic [3:0]  w_final;

  // Result vector including the bit being captured on this edge, so the
  // verdict at the last sample already sees vector 11.
  always_comb begin
    w_final        = r_result;
    w_final[r_idx] = io_bus.dut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_result <= 4'd0;
      r_fail   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_idx    <= 2'd0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_result <= 4'd0;
            r_fail   <= 4'd0;
            r_pass   <= 1'b0;
          end
        end
        RUN: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt    <= '0;
            r_result <= w_final;
            if (r_idx == 2'd3) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_fail  <= w_final ^ EXPECTED;
              r_pass  <= (w_final == EXPECTED);
              r_a     <= 1'b0;
              r_b     <= 1'b0;
              r_idx   <= 2'd0;
            end else begin
              r_idx          <= r_idx + 2'd1;
              {r_a, r_b}     <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.dut_a      = r_a;
  assign io_bus.dut_b      = r_b;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.pass       = r_pass;
  assign io_bus.result_vec = r_result;
  assign io_bus.fail_mask  = r_fail;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: an AND instance (default timing, optional
// stuck-at-1 output) and an OR instance with zero settle cycles.
module tb_gate_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   cyc;
  int   found;

  always #5 clk = ~clk;

  gate_bist_if and_if ();
  gate_bist_if or_if ();

  assign and_if.dut_out = stuck ? 1'b1 : (and_if.dut_a & and_if.dut_b);
  assign or_if.dut_out  = or_if.dut_a | or_if.dut_b;

  gate_bist u_and (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (and_if.slave)
  );

  gate_bist #(.EXPECTED(4'b1110), .SETTLE_CYCLES(0)) u_or (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (or_if.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges after the accepting edge until done is seen; -1 if it never shows.
  task automatic wait_done_and(output int c);
    c = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (and_if.done === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    and_if.start = 1'b0;
    or_if.start  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", {7'd0, and_if.busy}, 8'd0);
    chk("rst_done", {7'd0, and_if.done}, 8'd0);
    chk("rst_pass", {7'd0, and_if.pass}, 8'd0);
    chk("rst_result", {4'd0, and_if.result_vec}, 8'd0);
    chk("rst_fail", {4'd0, and_if.fail_mask}, 8'd0);
    chk("rst_ab", {6'd0, and_if.dut_a, and_if.dut_b}, 8'd0);
    rst_n = 1'b1;
    tick();

    // AND gate, default settle; extra start pulse at E0+5 must be ignored
    and_if.start = 1'b1;
    tick();
    and_if.start = 1'b0;
    chk("and_busy_e0", {7'd0, and_if.busy}, 8'd1);
    chk("and_ab_e0", {6'd0, and_if.dut_a, and_if.dut_b}, 8'd0);
    for (int n = 1; n <= 12; n++) begin
      if (n == 5) and_if.start = 1'b1;
      tick();
      and_if.start = 1'b0;
      if (n < 12) begin
        chk($sformatf("and_ab_e%0d", n), {6'd0, and_if.dut_a, and_if.dut_b}, 8'(n / 3));
        chk($sformatf("and_done_e%0d", n), {7'd0, and_if.done}, 8'd0);
      end
    end
    chk("and_done", {7'd0, and_if.done}, 8'd1);
    chk("and_busy_end", {7'd0, and_if.busy}, 8'd0);
    chk("and_result", {4'd0, and_if.result_vec}, 8'b1000);
    chk("and_fail", {4'd0, and_if.fail_mask}, 8'b0000);
    chk("and_pass", {7'd0, and_if.pass}, 8'd1);
    chk("and_ab_end", {6'd0, and_if.dut_a, and_if.dut_b}, 8'd0);
    $display("run and: result=%b fail=%b pass=%b", and_if.result_vec, and_if.fail_mask, and_if.pass);
    tick();
    chk("and_done_once", {7'd0, and_if.done}, 8'd0);
    chk("and_held_result", {4'd0, and_if.result_vec}, 8'b1000);
    chk("and_held_pass", {7'd0, and_if.pass}, 8'd1);
    repeat (3) tick();
    chk("and_no_second_run", {7'd0, and_if.busy}, 8'd0);

    // Stuck-at-1 output
    stuck = 1'b1;
    and_if.start = 1'b1;
    tick();
    and_if.start = 1'b0;
    wait_done_and(cyc);
    chk("sa1_done_cycle", 8'(cyc), 8'd12);
    chk("sa1_result", {4'd0, and_if.result_vec}, 8'b1111);
    chk("sa1_fail", {4'd0, and_if.fail_mask}, 8'b0111);
    chk("sa1_pass", {7'd0, and_if.pass}, 8'd0);
    $display("run sa1: result=%b fail=%b pass=%b", and_if.result_vec, and_if.fail_mask, and_if.pass);
    tick();

    // Continuous start: failing run, then automatic restart clears results
    and_if.start = 1'b1;
    tick();
    wait_done_and(cyc);
    chk("cont_done_cycle", 8'(cyc), 8'd12);
    chk("cont_fail_first", {4'd0, and_if.fail_mask}, 8'b0111);
    stuck = 1'b0;
    found = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (and_if.busy === 1'b1) begin
        found = i;
        break;
      end
    end
    chk("cont_restart_seen", {7'd0, (found >= 1 && found <= 2)}, 8'd1);
    chk("cont_clr_result", {4'd0, and_if.result_vec}, 8'd0);
    chk("cont_clr_fail", {4'd0, and_if.fail_mask}, 8'd0);
    chk("cont_clr_pass", {7'd0, and_if.pass}, 8'd0);
    and_if.start = 1'b0;
    wait_done_and(cyc);
    chk("cont2_done_cycle", 8'(cyc), 8'd12);
    chk("cont2_pass", {7'd0, and_if.pass}, 8'd1);
    $display("run cont: result=%b fail=%b pass=%b", and_if.result_vec, and_if.fail_mask, and_if.pass);
    tick();

    // Reset during vector 10
    and_if.start = 1'b1;
    tick();
    and_if.start = 1'b0;
    repeat (7) tick();
    chk("mid_ab_10", {6'd0, and_if.dut_a, and_if.dut_b}, 8'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {7'd0, and_if.busy}, 8'd0);
    chk("mid_ab", {6'd0, and_if.dut_a, and_if.dut_b}, 8'd0);
    chk("mid_pass", {7'd0, and_if.pass}, 8'd0);
    chk("mid_result", {4'd0, and_if.result_vec}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      chk($sformatf("mid_no_done_%0d", i), {7'd0, and_if.done}, 8'd0);
    end
    and_if.start = 1'b1;
    tick();
    and_if.start = 1'b0;
    wait_done_and(cyc);
    chk("post_rst_done_cycle", 8'(cyc), 8'd12);
    chk("post_rst_result", {4'd0, and_if.result_vec}, 8'b1000);
    chk("post_rst_pass", {7'd0, and_if.pass}, 8'd1);
    $display("run post_reset: result=%b fail=%b pass=%b", and_if.result_vec, and_if.fail_mask, and_if.pass);

    // OR gate, zero settle
    or_if.start = 1'b1;
    tick();
    or_if.start = 1'b0;
    chk("or_ab_e0", {6'd0, or_if.dut_a, or_if.dut_b}, 8'd0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 4) begin
        chk($sformatf("or_ab_e%0d", n), {6'd0, or_if.dut_a, or_if.dut_b}, 8'(n));
        chk($sformatf("or_done_e%0d", n), {7'd0, or_if.done}, 8'd0);
      end
    end
    chk("or_done", {7'd0, or_if.done}, 8'd1);
    chk("or_busy_end", {7'd0, or_if.busy}, 8'd0);
    chk("or_result", {4'd0, or_if.result_vec}, 8'b1110);
    chk("or_fail", {4'd0, or_if.fail_mask}, 8'b0000);
    chk("or_pass", {7'd0, or_if.pass}, 8'd1);
    $display("run or: result=%b fail=%b pass=%b", or_if.result_vec, or_if.fail_mask, or_if.pass);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
